// File: rtl/print_stream_packer.sv
// Packs console characters from the soft-core print_out port into 32-bit little-endian words
// and buffers them in a FIFO behind a valid/ready stream. Define PRINT_PACK_TIMEOUT_EN to enable idle flush.
module print_stream_packer #(
   parameter int FIFO_DEPTH    = 16,
   parameter int FLUSH_TIMEOUT = 255,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [48:0]          print_in,
   output logic [31:0]          dout,
   output logic                 val_out,
   input  logic                 ready_downward,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] drop_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   logic       chr_valid;
   logic [7:0] chr;
   logic       unused_bits;

   assign chr_valid   = print_in[48];
   assign chr         = print_in[7:0];
   assign unused_bits = ^print_in[47:8];

   // packer state
   logic [1:0]  lane_cnt;
   logic [31:0] lane_word;
   logic [31:0] merged;
   logic        flush_now;
   logic        timeout_now;
   logic        push_flag;
   logic [31:0] push_word;

   // FIFO state
   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             pop;
   logic             push_ok;

`ifdef PRINT_PACK_TIMEOUT_EN
   logic [15:0] timer;
`else
   localparam int UNUSED_TIMEOUT = FLUSH_TIMEOUT;
`endif

   // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      merged                           = lane_word;
      merged[{lane_cnt, 3'b000} +: 8]  = chr;
      flush_now                        = chr_valid && ((lane_cnt == 2'd3) || (chr == 8'h0A));
      timeout_now                      = 1'b0;
`ifdef PRINT_PACK_TIMEOUT_EN
      timeout_now = !chr_valid && (lane_cnt != 2'd0) && (timer == 16'(FLUSH_TIMEOUT - 1));
`endif
   end

   assign val_out = (count != '0);
   assign dout    = val_out ? mem[rd_ptr] : 32'h0;
   assign pop     = val_out && ready_downward;
   // A pop on the same edge frees a slot, so a full FIFO still accepts the word.
   assign push_ok = push_flag && ((count < DEPTH_CNT) || pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lane_cnt  <= 2'd0;
         lane_word <= 32'h0;
         push_flag <= 1'b0;
         push_word <= 32'h0;
      end else begin
         push_flag <= 1'b0;
         if (chr_valid) begin
            if (flush_now) begin
               push_word <= merged;
               push_flag <= 1'b1;
               lane_word <= 32'h0;
               lane_cnt  <= 2'd0;
            end else begin
               lane_word <= merged;
               lane_cnt  <= lane_cnt + 2'd1;
            end
         end else if (timeout_now) begin
            push_word <= lane_word;
            push_flag <= 1'b1;
            lane_word <= 32'h0;
            lane_cnt  <= 2'd0;
         end
      end
   end

`ifdef PRINT_PACK_TIMEOUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer <= 16'd0;
      end else if (chr_valid || timeout_now) begin
         timer <= 16'd0;
      end else if (lane_cnt != 2'd0) begin
         timer <= timer + 16'd1;
      end
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_flag && !push_ok) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // NOTE: the storage array has no reset; dout is masked by count, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_word;
   end

endmodule

// File: doc/print_stream_packer.md
Name: print_stream_packer

Overview:
- Sits directly downstream of the soft-core wrapper's `print_out` debug port.
- Collects the byte-wide console characters the core writes to address 0x1000_0000 and packs them little-endian into 32-bit words.
- Buffers the packed words in a small FIFO and presents them on a valid/ready stream, so console text can be forwarded over the same style of link as the data ports.
- `print_out` has no backpressure. The block therefore never stalls its input; it drops and counts words on overflow instead.

Parameters:
- FIFO_DEPTH, 16, number of 32-bit words buffered; power of two, minimum 2.
- FLUSH_TIMEOUT, 255, idle cycles after the last character before a partial word is flushed; range 1..65535.
- CNT_WIDTH, 16, width of the dropped-word counter.

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- resetn, input, 1, asynchronous active-low reset.
- print_in, input, 49, wrapper `print_out`:
  - bit 48 = character valid;
  - bits 7:0 = character;
  - bits 47:8 ignored.
- dout, output, 32, packed word at FIFO head; first character in [7:0].
- val_out, output, 1, dout valid.
- ready_downward, input, 1, consumer accepts dout this cycle.
- overflow, output, 1, sticky flag: at least one word was dropped since reset.
- drop_cnt, output, CNT_WIDTH, number of dropped words; saturates at all-ones.

Behaviour:
- Reset (asynchronous, while resetn=0) clears everything:
  - packer: lane count 0, shift register 0, timer 0, push flag 0;
  - FIFO: read and write pointers 0, count 0;
  - outputs: val_out=0, dout=0, overflow=0, drop_cnt=0.
- Reset asserted mid-operation discards all partial and buffered data; nothing is emitted after release.
- Packer lanes: lane count L = 0..3.
  - Character accepted when print_in[48]=1; it is written to byte lane L, then L increments.
- Flush conditions, evaluated on the accepting edge:
  - L was 3 (word full), or
  - character == 8'h0A (newline included; higher lanes zero-padded).
- On flush:
  - the word is latched into a push register with push flag = 1;
  - L returns to 0 and the lane register clears.
  - Any new character on the next cycle starts a fresh word. There is no stall.
- Push stage:
  - On the edge after the push flag is set, the word is written to the FIFO if count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped: overflow <= 1 and drop_cnt increments (saturating).
  - The push flag clears unless a new flush sets it on the same edge.
- Latency: a character that completes a word on edge E0 gives val_out=1 in the cycle after edge E0+1, i.e. 2 cycles. It is never earlier.
- FIFO output:
  - val_out = (count != 0);
  - dout = mem[rd_ptr], first-word fall-through.
  - Pop occurs when val_out && ready_downward.
  - dout and val_out must not change while val_out=1 and ready_downward=0.
- Simultaneous push and pop:
  - when full: the word is accepted, count unchanged;
  - when count=0: push only; the word appears on the next cycle.
- Pointers wrap modulo FIFO_DEPTH. count has width log2(FIFO_DEPTH)+1.
- print_in[48]=0 never changes packer state, except through the timer (see Optional Feature).

Optional Feature:
- Macro: PRINT_PACK_TIMEOUT_EN.
- Defined:
  - The timer resets to 0 on every accepted character.
  - While L>0 and no character arrives, the timer increments each cycle.
  - When it reaches FLUSH_TIMEOUT, the partial word is flushed (unused lanes zero), L=0, timer=0.
  - A character arriving on the same edge as the timeout is packed normally and the timeout is cancelled.
- Undefined: no timer logic. Partial words flush only on newline or when full, so a trailing partial word stays held indefinitely.

Test Plan:
1. Feed 'A','B','C','D' on consecutive cycles with ready_downward=1 -> one word 32'h44434241, val_out high exactly 2 cycles after 'D'; no further words.
2. Feed 'h','i',8'h0A -> word 32'h000A6968; then 'x' packs into lane 0 of the next word.
3. Hold ready_downward=0 and push 17 full words with FIFO_DEPTH=16 -> 16 stored, overflow=1, drop_cnt=1. Then drain -> 16 words in order, dout stable while stalled.
4. With the FIFO full and ready_downward=1, complete a word on the same edge as a pop -> no drop, count stays 16, drop_cnt unchanged.
5. With PRINT_PACK_TIMEOUT_EN and FLUSH_TIMEOUT=8: send 'Z', then idle -> word 32'h0000005A flushed 8 cycles later. Without the macro, no word after 100 idle cycles.
6. Assert resetn low mid-word and with 3 words buffered -> val_out=0, dout=0, overflow=0, drop_cnt=0 immediately (asynchronous). After release, nothing is emitted until new characters arrive.
